mips_init_loader: RTL and testbench
===================================

# mips_init_loader

Boot loader that sits in front of the MIPS core's initialization port. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives `init`/`init_addr`/`init_data` one word per write. It holds the core in reset until a checksum-verified image has been written, then releases it.

## Interface
Parameters:
- ADDR_W, 8, width of `init_addr`; addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, address of the first written word.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- reload  in  1  single-cycle request to start a new load; honoured only in DONE or ERROR.
- init  out  1  one-cycle write strobe to the core's init port.
- init_addr  out  ADDR_W  word address for init_data.
- init_data  out  32  assembled word.
- cpu_reset  out  1  holds the core in reset; high unless in DONE.
- done  out  1  image loaded and verified.
- err  out  1  checksum mismatch.

## Operation
- Stream format: count byte N (0 encodes 256), then 4·N data bytes, MSB first per word, then one checksum byte. The checksum byte equals the XOR of all 4·N data bytes. The count byte is not included in the checksum.
- A byte transfers on a rising edge where in_valid && in_ready. No other byte is consumed.
- States:
  - IDLE: in_ready=1. The accepted byte loads the word counter (0 → 256), clears the XOR accumulator and word index → ASSEMBLE.
  - ASSEMBLE: in_ready=1. Each accepted byte shifts into the word register (new byte into bits [7:0]) and XORs into the accumulator. Byte counter 0..3; the 4th byte goes → WRITE.
  - WRITE: in_ready=0. init=1 for exactly one cycle, with init_addr=(BASE_ADDR+index) mod 2^ADDR_W and init_data=the assembled word. Then index+1 and remaining−1. If remaining reaches 0 → CHECK, else → ASSEMBLE.
  - CHECK: in_ready=1. On the accepted byte: if it equals the accumulator → DONE, else → ERROR.
  - DONE: in_ready=0, done=1, cpu_reset=0. The input stream is ignored. reload → IDLE.
  - ERROR: in_ready=0, err=1, cpu_reset=1. reload → IDLE.
- Output rules:
  - init_addr and init_data are registered and hold their last values when init=0.
  - cpu_reset is registered and is high in every state except DONE.
- reload is ignored in IDLE, ASSEMBLE, WRITE and CHECK. Leaving DONE via reload reasserts cpu_reset on the same edge the state leaves DONE, and clears done/err.
- A stalled stream (in_valid=0) is allowed indefinitely in any accepting state; no timeout.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, init=0, init_addr=0, init_data=0, cpu_reset=1, done=0, err=0, and all counters and the accumulator 0.
- in_ready is combinational from state only and does not depend on in_valid. It reads 1 once reset deasserts. No byte is accepted while reset is high.
- Latency: the edge accepting a word's 4th byte moves the state to WRITE, so init=1 during the following cycle. At full rate a new byte can be accepted no earlier than the cycle after WRITE, giving 5 cycles per word minimum.
- Checksum byte accepted on edge k → done (or err) high and cpu_reset low (DONE only) from edge k onward.
- Address wrap: with BASE_ADDR=0xFE and N=4, the writes go to 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-load: all state is discarded, cpu_reset returns to 1 immediately, and a partial image is not completed; the next byte after reset is treated as a count.

## Test plan
- Basic load, BASE_ADDR=0: bytes 02, 11 22 33 44, A0 B0 C0 D0, checksum 44 → init pulses at addr 0 with 0x11223344 and at addr 1 with 0xA0B0C0D0; done=1, cpu_reset=0, err=0.
- Bad checksum: same image with checksum 45 → both writes still occur, then err=1, done=0, cpu_reset stays 1. A reload pulse returns to IDLE with err=0.
- Backpressure and gaps: in_valid toggled randomly → exactly the same init sequence as back-to-back input; in_ready=0 during every init cycle, and no byte is lost or duplicated.
- Count 0 with BASE_ADDR=0xFE: 256 words → 256 init pulses, with addresses running 0xFE, 0xFF, 0x00 … 0xFD; done after the checksum.
- Reset asserted after the 2nd data byte of word 0 → outputs return to reset values immediately. A fresh stream 01, DE AD BE EF, checksum 0x22 → one write of 0xDEADBEEF at BASE_ADDR, then done.
- reload asserted during ASSEMBLE → ignored. reload in DONE → cpu_reset=1 and done=0 on that edge, and a second image loads correctly.

Source files
------------

// File: rtl/mips_init_loader.sv
// ---------------------------------------------------------------------------
// mips_init_loader
// Boot loader in front of the MIPS core's initialization port. It takes a
// byte stream over a valid/ready handshake. The stream is a count byte N
// (0 means 256), then 4*N data bytes (each word MSB first), then a checksum
// byte equal to the XOR of all data bytes. Each assembled big-endian word is
// written to the core with a one-cycle init strobe. The core is held in
// reset until the whole image has been written and its checksum verified.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   a byte is offered on in_data
//   in_data    stream byte
//   in_ready   loader can accept a byte this cycle (depends on state only)
//   reload     start a new load; honoured only in DONE or ERROR
//   init       one-cycle write strobe to the core's init port
//   init_addr  word address, (BASE_ADDR + word index) mod 2^ADDR_W
//   init_data  assembled 32-bit word
//   cpu_reset  core reset, low only while DONE
//   done       image loaded and verified
//   err        checksum mismatch
// ---------------------------------------------------------------------------
module mips_init_loader #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              init,
   output logic [ADDR_W-1:0] init_addr,
   output logic [31:0]       init_data,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      ASSEMBLE,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [8:0]        remaining;
   logic [1:0]        byte_cnt;
   logic [7:0]        acc;
   logic [23:0]       word_reg;
   logic [ADDR_W-1:0] index;
   logic              accept;

   // Ready is a pure function of state so a producer never sees it react to
   // its own valid.
   assign in_ready = (state == IDLE) || (state == ASSEMBLE) || (state == CHECK);
   assign accept   = in_valid && in_ready;

   // Next-state logic. WRITE always lasts exactly one cycle; the last word
   // (remaining == 1 before the decrement) leads to the checksum byte.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (accept) next_state = ASSEMBLE;
         ASSEMBLE: if (accept && byte_cnt == 2'd3) next_state = WRITE;
         WRITE:    next_state = (remaining == 9'd1) ? CHECK : ASSEMBLE;
         CHECK:    if (accept) next_state = (in_data == acc) ? DONE : ERROR;
         DONE:     if (reload) next_state = IDLE;
         ERROR:    if (reload) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // State register plus datapath. The status outputs and the init strobe
   // are registered from next_state so they change on the same edge as the
   // state they describe (e.g. cpu_reset rises on the edge leaving DONE).
   // The 4th byte of a word goes straight into init_data, so the word is
   // ready during the WRITE cycle without an extra stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         init      <= 1'b0;
         init_addr <= '0;
         init_data <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         remaining <= '0;
         byte_cnt  <= '0;
         acc       <= '0;
         word_reg  <= '0;
         index     <= '0;
      end else begin
         state     <= next_state;
         init      <= (next_state == WRITE);
         cpu_reset <= (next_state != DONE);
         done      <= (next_state == DONE);
         err       <= (next_state == ERROR);
         case (state)
            IDLE: begin
               if (accept) begin
                  remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  acc       <= '0;
                  index     <= '0;
                  byte_cnt  <= '0;
               end
            end
            ASSEMBLE: begin
               if (accept) begin
                  word_reg <= {word_reg[15:0], in_data};
                  acc      <= acc ^ in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     init_data <= {word_reg, in_data};
                     init_addr <= BASE_ADDR + index;
                  end
               end
            end
            WRITE: begin
               index     <= index + ADDR_W'(1);
               remaining <= remaining - 9'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_init_loader.sv
// ---------------------------------------------------------------------------
// tb_mips_init_loader
// Two loaders (BASE_ADDR 0 and 0xFE) share one input stream. Each write the
// bench expects is queued when the word's last byte is driven. A monitor pops
// that entry whenever init strobes and compares address and data for both
// instances.
// ---------------------------------------------------------------------------
module tb_mips_init_loader;

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        inValid;
   logic [7:0]  inData;
   logic        reload;

   logic        inReady0, init0, cpuReset0, done0, err0;
   logic [7:0]  initAddr0;
   logic [31:0] initData0;
   logic        inReady1, init1, cpuReset1, done1, err1;
   logic [7:0]  initAddr1;
   logic [31:0] initData1;

   exp_t        expQ[$];
   exp_t        monE;
   logic [31:0] img[$];
   int          testsRun  = 0;
   int          failCount = 0;

   always #5 clock = ~clock;

   mips_init_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
      .clk(clock), .reset(reset), .in_valid(inValid), .in_data(inData),
      .in_ready(inReady0), .reload(reload), .init(init0),
      .init_addr(initAddr0), .init_data(initData0), .cpu_reset(cpuReset0),
      .done(done0), .err(err0)
   );

   mips_init_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
      .clk(clock), .reset(reset), .in_valid(inValid), .in_data(inData),
      .in_ready(inReady1), .reload(reload), .init(init1),
      .init_addr(initAddr1), .init_data(initData1), .cpu_reset(cpuReset1),
      .done(done1), .err(err1)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Scoreboard monitor: every init strobe must match the oldest queued write.
   always @(negedge clock) begin
      if (init0 === 1'b1) begin
         checkOutput("ready_during_init", {31'd0, inReady0}, 32'd0);
         checkOutput("init_strobe_fe", {31'd0, init1}, 32'd1);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_init", 32'd1, 32'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("addr_base00", {24'd0, initAddr0}, {24'd0, monE.idx});
            checkOutput("data_base00", initData0, monE.data);
            checkOutput("addr_basefe", {24'd0, initAddr1}, {24'd0, 8'hFE + monE.idx});
            checkOutput("data_basefe", initData1, monE.data);
         end
      end
   end

   // Overall time limit so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Offer one byte and hold it until the loader takes it. With gaps set, a
   // random number of idle cycles precede the byte. Returns 1 time unit after
   // the accepting edge.
   task automatic sendByte(input logic [7:0] b, input bit gaps);
      int waitCycles;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
      @(negedge clock);
      inValid = 1'b1;
      inData  = b;
      waitCycles = 0;
      while (inReady0 !== 1'b1 && waitCycles < 50) begin
         @(negedge clock);
         waitCycles++;
      end
      if (waitCycles >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
      inValid = 1'b0;
      inData  = 8'($urandom);
   endtask

   // Send count, the words in img and the checksum (optionally corrupted).
   // With midReload, a reload pulse lands while the first word is assembling.
   task automatic applyStimulus(input logic [7:0] countByte, input bit gaps,
                                input bit badSum, input bit midReload);
      logic [7:0]  sum;
      logic [31:0] word;
      logic [7:0]  b;
      exp_t        e;
      sum = 8'd0;
      sendByte(countByte, gaps);
      for (int w = 0; w < img.size(); w++) begin
         word = img[w];
         for (int k = 0; k < 4; k++) begin
            b   = word[31:24];
            word = word << 8;
            sum = sum ^ b;
            if (k == 3) begin
               e.idx  = 8'(w);
               e.data = img[w];
               expQ.push_back(e);
            end
            sendByte(b, gaps);
            if (k == 3) checkOutput("init_latency", {31'd0, init0}, 32'd1);
            if (midReload && w == 0 && k == 1) begin
               @(negedge clock);
               reload = 1'b1;
               @(negedge clock);
               reload = 1'b0;
            end
         end
      end
      sendByte(badSum ? (sum ^ 8'h01) : sum, gaps);
      checkOutput("done",       {31'd0, done0},     {31'd0, !badSum});
      checkOutput("err",        {31'd0, err0},      {31'd0, badSum});
      checkOutput("cpu_reset",  {31'd0, cpuReset0}, {31'd0, badSum});
      checkOutput("done_fe",    {31'd0, done1},     {31'd0, !badSum});
      checkOutput("err_fe",     {31'd0, err1},      {31'd0, badSum});
      checkOutput("ready_end",  {31'd0, inReady0},  32'd0);
      checkOutput("writes_left", 32'(expQ.size()),  32'd0);
   endtask

   // One-cycle reload; the loader must be back in IDLE with the core held.
   task automatic pulseReload();
      @(negedge clock);
      reload = 1'b1;
      @(posedge clock);
      #1;
      reload = 1'b0;
      checkOutput("reload_cpu_reset", {31'd0, cpuReset0}, 32'd1);
      checkOutput("reload_done",      {31'd0, done0},     32'd0);
      checkOutput("reload_err",       {31'd0, err0},      32'd0);
      checkOutput("reload_ready",     {31'd0, inReady0},  32'd1);
   endtask

   initial begin
      reset   = 1'b1;
      inValid = 1'b0;
      inData  = 8'd0;
      reload  = 1'b0;
      #2;
      checkOutput("rst_init",      {31'd0, init0},     32'd0);
      checkOutput("rst_addr",      {24'd0, initAddr0}, 32'd0);
      checkOutput("rst_data",      initData0,          32'd0);
      checkOutput("rst_cpu_reset", {31'd0, cpuReset0}, 32'd1);
      checkOutput("rst_done",      {31'd0, done0},     32'd0);
      checkOutput("rst_err",       {31'd0, err0},      32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("ready_after_rst", {31'd0, inReady0}, 32'd1);

      // Basic image, then reload from DONE.
      img = '{32'h11223344, 32'hA0B0C0D0};
      applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
      pulseReload();

      // Same image with a wrong checksum, then reload from ERROR.
      applyStimulus(8'h02, 1'b0, 1'b1, 1'b0);
      pulseReload();

      // Gapped stream, plus a reload pulse during ASSEMBLE that must be ignored.
      applyStimulus(8'h02, 1'b1, 1'b0, 1'b1);
      pulseReload();
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back($urandom);
      applyStimulus(8'h06, 1'b1, 1'b0, 1'b0);
      pulseReload();

      // Count 0 means 256 words; addresses wrap on the 0xFE instance.
      img.delete();
      for (int i = 0; i < 256; i++) img.push_back($urandom);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      pulseReload();

      // Reset after the 2nd data byte of word 0 discards the partial image.
      sendByte(8'h02, 1'b0);
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("midrst_addr",      {24'd0, initAddr0}, 32'd0);
      checkOutput("midrst_data",      initData0,          32'd0);
      checkOutput("midrst_cpu_reset", {31'd0, cpuReset0}, 32'd1);
      checkOutput("midrst_done",      {31'd0, done0},     32'd0);
      @(negedge clock);
      reset = 1'b0;
      img = '{32'hDEADBEEF};
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clock);
      checkOutput("final_writes_left", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
